inst_axi_bridge: RTL and testbench

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge.sv | 119 +++++++++++
 tb/tb_inst_axi_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch bridge: converts SRAM-like fetch requests into single-beat AXI reads.
// Up to MAX_OUTSTANDING reads may be in flight; responses return in order on a single ID.
module inst_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID           = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_mat,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;

  ar_state_t        r_state;
  ar_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_araddr;
  logic [2:0]       r_arsize;
  logic [3:0]       r_arcache;
  logic             w_addr_ok;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_unused;

  // Response ID, status and last flag carry no information for single-beat, single-ID reads.
  assign w_unused = &{1'b0, rid, rresp, rlast};

  // resetn gates the accept so no request is acknowledged while reset is held.
  assign w_addr_ok = resetn & inst_sram_req & ~inst_sram_wr &
                     (r_state == AR_IDLE) & (r_cnt < MAX_CNT);
  assign w_ar_hs   = arvalid & arready;
  assign w_r_hs    = rvalid & rready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= AR_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AR_IDLE: if (w_addr_ok) w_state_nxt = AR_SEND;
      AR_SEND: if (arready)   w_state_nxt = AR_IDLE;
      default:                w_state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    arvalid           = (r_state == AR_SEND);
    rready            = (r_cnt != '0);
    inst_sram_addr_ok = w_addr_ok;
    inst_sram_data_ok = w_r_hs;
    inst_sram_rdata   = rdata;
  end

  // Request attributes are captured at accept and held until the AR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr  <= 32'h0;
      r_arsize  <= 3'b000;
      r_arcache <= 4'b0000;
    end else if (w_addr_ok) begin
      r_araddr  <= inst_sram_addr;
      r_arsize  <= {1'b0, inst_sram_size};
      r_arcache <= inst_mat ? 4'b1111 : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      case ({w_addr_ok, w_r_hs})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arcache = r_arcache;
  assign arid    = AR_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: fetch, backpressure, outstanding limit,
// simultaneous accept/return, uncached error response, write stall and mid-flight reset.
module tb_inst_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_mat;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_chk  = 0;
  int n_pass = 0;

  inst_axi_bridge #(.MAX_OUTSTANDING(2), .AR_ID(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_mat(inst_mat), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    resetn = 1'b0; inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'b10;
    inst_sram_addr = 32'h1c00_0000; inst_mat = 1'b1; arready = 1'b1;
    rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    #3;
    check_val("rst_addr_ok", inst_sram_addr_ok, 0);
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_rready",  rready, 0);
    check_val("rst_araddr",  araddr, 0);
    check_val("rst_arcache", arcache, 0);
    check_val("rst_arsize",  arsize, 0);
    check_val("rst_cnt",     dut.r_cnt, 0);
    inst_sram_req = 1'b0;
    tick(); tick();
    resetn = 1'b1;

    // single cached fetch
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_mat = 1'b1; arready = 1'b1;
    #1 check_val("t1_addr_ok", inst_sram_addr_ok, 1);
    tick(); inst_sram_req = 1'b0;
    #1 check_val("t1_arvalid", arvalid, 1);
    check_val("t1_araddr",  araddr, 32'h1c00_0000);
    check_val("t1_arcache", arcache, 4'hF);
    check_val("t1_arsize",  arsize, 3'b010);
    check_val("t1_const",   {arid, arlen, arburst, arlock, arprot}, {4'h0, 8'd0, 2'b01, 2'b00, 3'b000});
    check_val("t1_addr_ok0", inst_sram_addr_ok, 0);
    check_val("t1_rready",  rready, 1);
    tick(); rvalid = 1'b1; rdata = 32'h0280_0421;
    #1 check_val("t1_data_ok", inst_sram_data_ok, 1);
    check_val("t1_rdata",   inst_sram_rdata, 32'h0280_0421);
    check_val("t1_arvalid0", arvalid, 0);
    tick(); rvalid = 1'b0;
    #1 check_val("t1_cnt0", dut.r_cnt, 0);
    check_val("t1_rready0", rready, 0);

    // AR backpressure: arready low for 3 cycles, req kept high
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0010; arready = 1'b0;
    #1 check_val("t2_addr_ok", inst_sram_addr_ok, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin arready = 1'b1; inst_sram_req = 1'b0; end
      #1 check_val("t2_arvalid", arvalid, 1);
      check_val("t2_araddr", araddr, 32'h1c00_0010);
      check_val("t2_addr_ok0", inst_sram_addr_ok, 0);
    end
    tick();
    #1 check_val("t2_after_hs", arvalid, 0);
    check_val("t2_cnt1", dut.r_cnt, 1);
    rvalid = 1'b1; rdata = 32'h0000_1111;
    #1 check_val("t2_data_ok", inst_sram_data_ok, 1);
    tick(); rvalid = 1'b0;
    #1 check_val("t2_cnt0", dut.r_cnt, 0);

    // outstanding limit with silent R channel
    pulses = 0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0100;
    for (int i = 0; i < 8; i++) begin
      #1 if (inst_sram_addr_ok) pulses++;
      tick();
    end
    check_val("t3_pulses", pulses, 2);
    check_val("t3_cnt2", dut.r_cnt, 2);
    rvalid = 1'b1; rdata = 32'h0000_2222;
    #1 check_val("t3_data_ok", inst_sram_data_ok, 1);
    check_val("t3_blocked", inst_sram_addr_ok, 0);
    tick(); rvalid = 1'b0;
    #1 check_val("t3_cnt_dec", dut.r_cnt, 1);
    check_val("t3_third", inst_sram_addr_ok, 1);
    tick(); inst_sram_req = 1'b0;
    #1 check_val("t3_cnt_back2", dut.r_cnt, 2);
    tick(); rvalid = 1'b1; rdata = 32'h0000_3333;
    #1 check_val("t3_drain_ok", inst_sram_data_ok, 1);

    // simultaneous accept and return at count 1
    tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0200; rdata = 32'h1234_5678;
    #1 check_val("t4_cnt_pre", dut.r_cnt, 1);
    check_val("t4_addr_ok", inst_sram_addr_ok, 1);
    check_val("t4_data_ok", inst_sram_data_ok, 1);
    check_val("t4_rdata", inst_sram_rdata, 32'h1234_5678);
    tick(); inst_sram_req = 1'b0; rvalid = 1'b0;
    #1 check_val("t4_cnt_same", dut.r_cnt, 1);
    check_val("t4_arvalid", arvalid, 1);
    tick(); rvalid = 1'b1; rdata = 32'h0000_4444;
    #1 check_val("t4_drain_ok", inst_sram_data_ok, 1);
    tick(); rvalid = 1'b0;
    #1 check_val("t4_cnt0", dut.r_cnt, 0);

    // uncached fetch with error response
    inst_sram_req = 1'b1; inst_mat = 1'b0; inst_sram_addr = 32'h0000_1000;
    #1 check_val("t5_addr_ok", inst_sram_addr_ok, 1);
    tick(); inst_sram_req = 1'b0; inst_mat = 1'b1;
    #1 check_val("t5_arcache", arcache, 4'h0);
    check_val("t5_araddr", araddr, 32'h0000_1000);
    tick(); rvalid = 1'b1; rresp = 2'b10; rid = 4'h5; rdata = 32'hDEAD_BEEF;
    #1 check_val("t5_data_ok", inst_sram_data_ok, 1);
    check_val("t5_rdata", inst_sram_rdata, 32'hDEAD_BEEF);
    tick(); rvalid = 1'b0; rresp = 2'b00; rid = 4'h0;
    #1 check_val("t5_cnt0", dut.r_cnt, 0);

    // write requests are never accepted
    inst_sram_req = 1'b1; inst_sram_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("t6_wr_addr_ok", inst_sram_addr_ok, 0);
      tick();
      check_val("t6_wr_arvalid", arvalid, 0);
    end
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;

    // asynchronous reset while an AR is pending
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0020; arready = 1'b0;
    #1 check_val("t7_addr_ok", inst_sram_addr_ok, 1);
    tick(); inst_sram_req = 1'b0;
    #1 check_val("t7_arvalid", arvalid, 1);
    check_val("t7_cnt1", dut.r_cnt, 1);
    #1 resetn = 1'b0;
    #1 check_val("t7_rst_arvalid", arvalid, 0);
    check_val("t7_rst_rready", rready, 0);
    check_val("t7_rst_cnt", dut.r_cnt, 0);
    check_val("t7_rst_araddr", araddr, 0);
    tick(); tick();
    resetn = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0030; arready = 1'b1;
    #1 check_val("t7_first_ok", inst_sram_addr_ok, 1);
    tick(); inst_sram_req = 1'b0;
    #1 check_val("t7_araddr", araddr, 32'h1c00_0030);
    tick(); rvalid = 1'b1; rdata = 32'h0000_5555;
    #1 check_val("t7_data_ok", inst_sram_data_ok, 1);
    tick(); rvalid = 1'b0;
    #1 check_val("t7_cnt0", dut.r_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
